dmem_bridge: RTL and testbench

DMEM_BRIDGE -- requirements
Module: dmem_bridge

---
 rtl/dmem_bridge.sv | 172 +++++++++++++++++
 tb/tb_dmem_bridge.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : dmem_bridge
// Purpose  : Bridges the pipeline memory stage to a simple req/ack data bus.
//            Checks alignment, builds byte strobes and lane-replicated store
//            data, stalls the pipeline while an access is outstanding and
//            returns the sign/zero-extended load result.
// Ports    : clk, rst                    - clock, synchronous active-high reset
//            memenM, memwriteM, addrM,
//            wdataM, sizeM, unsignedM    - access request from memory stage
//            stallM, rdataM, adelM, adesM- stall, load result, alignment errors
//            bus_req, bus_wr, bus_addr,
//            bus_wstrb, bus_wdata        - bus request side (registered)
//            bus_ack, bus_rdata          - bus response side
// Revision : 1.0 - initial release
// ============================================================================
module dmem_bridge (
  input  logic        clk,
  input  logic        rst,
  input  logic        memenM,
  input  logic        memwriteM,
  input  logic [31:0] addrM,
  input  logic [31:0] wdataM,
  input  logic [1:0]  sizeM,
  input  logic        unsignedM,
  output logic        stallM,
  output logic [31:0] rdataM,
  output logic        adelM,
  output logic        adesM,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [1:0]  r_state;
  logic [1:0]  w_next_state;
  logic        w_err;
  logic        w_launch;
  logic [3:0]  w_strb;
  logic [31:0] w_wdata;

  // Access attributes kept for the load-extraction step once the bus answers.
  logic [1:0]  r_size;
  logic [1:0]  r_off;
  logic        r_unsigned;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;

  // Reserved size or a halfword/word not naturally aligned.
  always_comb begin
    w_err = 1'b0;
    case (sizeM)
      SZ_BYTE: w_err = 1'b0;
      SZ_HALF: w_err = addrM[0];
      SZ_WORD: w_err = (addrM[1:0] != 2'b00);
      default: w_err = 1'b1;
    endcase
  end

  assign w_launch = (r_state == S_IDLE) && memenM && !w_err;

  always_comb begin
    w_strb  = 4'b1111;
    w_wdata = wdataM;
    case (sizeM)
      SZ_BYTE: begin
        w_strb  = 4'b0001 << addrM[1:0];
        w_wdata = {4{wdataM[7:0]}};
      end
      SZ_HALF: begin
        w_strb  = 4'b0011 << addrM[1:0];
        w_wdata = {2{wdataM[15:0]}};
      end
      default: begin
        w_strb  = 4'b1111;
        w_wdata = wdataM;
      end
    endcase
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_launch) w_next_state = S_REQ;
      S_REQ:   if (bus_ack)  w_next_state = S_DONE;
      // DONE always falls back to IDLE so the still-asserted memenM of the
      // completing instruction is not launched a second time.
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    stallM  = 1'b0;
    adelM   = 1'b0;
    adesM   = 1'b0;
    bus_req = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!rst && memenM) begin
          stallM = !w_err;
          adelM  = w_err && !memwriteM;
          adesM  = w_err && memwriteM;
        end
      end
      S_REQ: begin
        stallM  = !rst;
        bus_req = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------- Datapath
  always_comb begin
    w_byte = bus_rdata[{r_off, 3'b000} +: 8];
    w_half = bus_rdata[{r_off[1], 4'b0000} +: 16];
    case (r_size)
      SZ_BYTE: w_load = {{24{!r_unsigned && w_byte[7]}}, w_byte};
      SZ_HALF: w_load = {{16{!r_unsigned && w_half[15]}}, w_half};
      default: w_load = bus_rdata;
    endcase
  end

  // Bus fields are written only at launch, so they stay stable through REQ.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_wr     <= 1'b0;
      bus_addr   <= 32'h0;
      bus_wstrb  <= 4'h0;
      bus_wdata  <= 32'h0;
      rdataM     <= 32'h0;
      r_size     <= 2'b00;
      r_off      <= 2'b00;
      r_unsigned <= 1'b0;
    end else begin
      if (w_launch) begin
        bus_wr     <= memwriteM;
        bus_addr   <= {addrM[31:2], 2'b00};
        bus_wstrb  <= memwriteM ? w_strb : 4'h0;
        bus_wdata  <= memwriteM ? w_wdata : 32'h0;
        r_size     <= sizeM;
        r_off      <= addrM[1:0];
        r_unsigned <= unsignedM;
      end
      if ((r_state == S_REQ) && bus_ack && !bus_wr) begin
        rdataM <= w_load;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_bridge
// Purpose  : Self-checking bench for dmem_bridge with a scoreboard queue of
//            expected bus transactions and load results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_bridge;

  logic        clk = 1'b0;
  logic        rst, memenM, memwriteM, unsignedM;
  logic [31:0] addrM, wdataM;
  logic [1:0]  sizeM;
  logic        stallM, adelM, adesM;
  logic [31:0] rdataM;
  logic        bus_req, bus_wr, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wstrb;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_bridge dut (
    .clk(clk), .rst(rst), .memenM(memenM), .memwriteM(memwriteM),
    .addrM(addrM), .wdataM(wdataM), .sizeM(sizeM), .unsignedM(unsignedM),
    .stallM(stallM), .rdataM(rdataM), .adelM(adelM), .adesM(adesM),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_addr(bus_addr),
    .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    int          stall;
    logic [31:0] rdata;
  } exp_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    int          waits;
    logic [31:0] rword;
    logic [31:0] baddr;
    logic [3:0]  strb;
    logic [31:0] bwdata;
    logic [31:0] rexp;
  } vec_t;

  exp_t exp_q[$];
  exp_t e;
  int checks = 0;
  int passes = 0;
  logic [31:0] last_rdata;

  // Observations gathered by run_access
  logic        o_wr, o_sawreq, o_adel, o_ades;
  logic [31:0] o_addr, o_wdata, o_rdata;
  logic [3:0]  o_strb;
  int          o_stall, o_done_cyc, o_req_cyc;

  // Drives one access starting just after a rising edge and plays the bus
  // responder; returns at the next edge after the first non-stall cycle.
  task automatic run_access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [1:0] size, input logic uns, input int waits,
                            input logic [31:0] rword, input logic hold);
    int wc;
    wc = 0;
    memenM = 1'b1; memwriteM = wr; addrM = addr; wdataM = wdata;
    sizeM = size; unsignedM = uns; bus_ack = 1'b0; bus_rdata = 32'h0;
    o_stall = 0; o_sawreq = 1'b0; o_adel = 1'b0; o_ades = 1'b0;
    o_wr = 1'b0; o_addr = 32'h0; o_strb = 4'h0; o_wdata = 32'h0; o_rdata = 32'h0;
    o_req_cyc = -1; o_done_cyc = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 0) begin o_adel = adelM; o_ades = adesM; end
      if (stallM) o_stall++;
      if (bus_req) begin
        if (!o_sawreq) begin
          o_sawreq = 1'b1; o_req_cyc = cyc;
          o_wr = bus_wr; o_addr = bus_addr; o_strb = bus_wstrb; o_wdata = bus_wdata;
        end
        if (wc == waits) begin bus_ack = 1'b1; bus_rdata = rword; end
        else wc++;
      end
      if (!stallM) begin o_done_cyc = cyc; o_rdata = rdataM; break; end
    end
    @(posedge clk); #1;
    bus_ack = 1'b0; bus_rdata = 32'h0;
    if (!hold) memenM = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; memenM = 1'b1; memwriteM = 1'b0; addrM = 32'h101; sizeM = 2'b10;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({stallM, adelM, adesM} !== 3'b000) $display("FAIL reset_comb_err: got stall/adel/ades=%b want 000", {stallM, adelM, adesM});
    else passes++;
    addrM = 32'h100;
    @(negedge clk);
    checks++;
    if (stallM !== 1'b0) $display("FAIL reset_stall: got %b want 0", stallM);
    else passes++;
    checks++;
    if ({bus_req, bus_wr, bus_addr, bus_wstrb, bus_wdata, rdataM} !== 102'h0)
      $display("FAIL reset_regs: got req=%b wr=%b addr=%h strb=%b wdata=%h rdata=%h want all 0",
               bus_req, bus_wr, bus_addr, bus_wstrb, bus_wdata, rdataM);
    else passes++;
    @(posedge clk); #1;
    rst = 1'b0; memenM = 1'b0;
  endtask

  task automatic test_word_load();
    exp_q.push_back('{1'b0, 32'h100, 4'b0000, 32'h0, 5, 32'hDEADBEEF});
    run_access(1'b0, 32'h100, 32'h0, 2'b10, 1'b0, 3, 32'hDEADBEEF, 1'b0);
    e = exp_q.pop_front();
    checks++;
    if ({o_sawreq, o_wr, o_addr, o_strb} !== {1'b1, e.wr, e.addr, e.strb})
      $display("FAIL word_load_bus: got req=%b wr=%b addr=%h strb=%b want 1 %b %h %b", o_sawreq, o_wr, o_addr, o_strb, e.wr, e.addr, e.strb);
    else passes++;
    checks++;
    if (o_stall !== e.stall) $display("FAIL word_load_stall: got %0d want %0d", o_stall, e.stall);
    else passes++;
    checks++;
    if (o_rdata !== e.rdata) $display("FAIL word_load_rdata: got %h want %h", o_rdata, e.rdata);
    else passes++;
    last_rdata = e.rdata;
  endtask

  task automatic test_loads();
    vec_t tbl[7];
    tbl[0] = '{1'b0, 32'h203, 32'h0, 2'b00, 1'b0, 0, 32'h80FF1234, 32'h200, 4'h0, 32'h0, 32'hFFFFFF80};
    tbl[1] = '{1'b0, 32'h203, 32'h0, 2'b00, 1'b1, 0, 32'h80FF1234, 32'h200, 4'h0, 32'h0, 32'h00000080};
    tbl[2] = '{1'b0, 32'h400, 32'h0, 2'b00, 1'b1, 1, 32'h44332211, 32'h400, 4'h0, 32'h0, 32'h00000011};
    tbl[3] = '{1'b0, 32'h401, 32'h0, 2'b00, 1'b0, 0, 32'h44332211, 32'h400, 4'h0, 32'h0, 32'h00000022};
    tbl[4] = '{1'b0, 32'h402, 32'h0, 2'b01, 1'b0, 2, 32'h80001234, 32'h400, 4'h0, 32'h0, 32'hFFFF8000};
    tbl[5] = '{1'b0, 32'h500, 32'h0, 2'b01, 1'b1, 0, 32'h1234F00D, 32'h500, 4'h0, 32'h0, 32'h0000F00D};
    tbl[6] = '{1'b0, 32'h500, 32'h0, 2'b01, 1'b0, 0, 32'h1234F00D, 32'h500, 4'h0, 32'h0, 32'hFFFFF00D};
    foreach (tbl[i]) begin
      exp_q.push_back('{1'b0, tbl[i].baddr, tbl[i].strb, 32'h0, 2 + tbl[i].waits, tbl[i].rexp});
      run_access(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].size, tbl[i].uns, tbl[i].waits, tbl[i].rword, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if ({o_sawreq, o_wr, o_addr, o_strb} !== {1'b1, e.wr, e.addr, e.strb} || o_stall !== e.stall)
        $display("FAIL load%0d_bus: got req=%b wr=%b addr=%h strb=%b stall=%0d want 1 %b %h %b %0d",
                 i, o_sawreq, o_wr, o_addr, o_strb, o_stall, e.wr, e.addr, e.strb, e.stall);
      else passes++;
      checks++;
      if (o_rdata !== e.rdata) $display("FAIL load%0d_rdata: got %h want %h", i, o_rdata, e.rdata);
      else passes++;
      last_rdata = e.rdata;
    end
  endtask

  task automatic test_stores();
    vec_t tbl[3];
    tbl[0] = '{1'b1, 32'h302, 32'h0000ABCD, 2'b01, 1'b0, 0, 32'h5555AAAA, 32'h300, 4'b1100, 32'hABCDABCD, 32'h0};
    tbl[1] = '{1'b1, 32'h301, 32'hFFFFFF5A, 2'b00, 1'b0, 1, 32'h5555AAAA, 32'h300, 4'b0010, 32'h5A5A5A5A, 32'h0};
    tbl[2] = '{1'b1, 32'h304, 32'h12345678, 2'b10, 1'b0, 2, 32'h5555AAAA, 32'h304, 4'b1111, 32'h12345678, 32'h0};
    foreach (tbl[i]) begin
      exp_q.push_back('{1'b1, tbl[i].baddr, tbl[i].strb, tbl[i].bwdata, 2 + tbl[i].waits, last_rdata});
      run_access(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].size, tbl[i].uns, tbl[i].waits, tbl[i].rword, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if ({o_sawreq, o_wr, o_addr, o_strb, o_wdata} !== {1'b1, e.wr, e.addr, e.strb, e.wdata})
        $display("FAIL store%0d_bus: got req=%b wr=%b addr=%h strb=%b wdata=%h want 1 %b %h %b %h",
                 i, o_sawreq, o_wr, o_addr, o_strb, o_wdata, e.wr, e.addr, e.strb, e.wdata);
      else passes++;
      checks++;
      if (o_stall !== e.stall) $display("FAIL store%0d_stall: got %0d want %0d", i, o_stall, e.stall);
      else passes++;
      checks++;
      if (o_rdata !== e.rdata) $display("FAIL store%0d_rdata_kept: got %h want %h", i, o_rdata, e.rdata);
      else passes++;
    end
  endtask

  task automatic test_misaligned();
    vec_t tbl[4];
    int reqs;
    // adel/ades expectation carried in rexp[1:0] as {adel, ades}
    tbl[0] = '{1'b0, 32'h101, 32'h0, 2'b10, 1'b0, 0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h2};
    tbl[1] = '{1'b1, 32'h102, 32'h0, 2'b10, 1'b0, 0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h1};
    tbl[2] = '{1'b0, 32'h301, 32'h0, 2'b01, 1'b0, 0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h2};
    tbl[3] = '{1'b1, 32'h000, 32'h0, 2'b11, 1'b0, 0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h1};
    foreach (tbl[i]) begin
      run_access(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].size, tbl[i].uns, 0, 32'h0, 1'b1);
      reqs = o_sawreq ? 1 : 0;
      repeat (3) begin
        @(negedge clk);
        if (bus_req || stallM) reqs++;
      end
      @(posedge clk); #1; memenM = 1'b0;
      checks++;
      if ({o_adel, o_ades} !== tbl[i].rexp[1:0])
        $display("FAIL err%0d_flags: got adel/ades=%b want %b", i, {o_adel, o_ades}, tbl[i].rexp[1:0]);
      else passes++;
      checks++;
      if (o_stall !== 0) $display("FAIL err%0d_stall: got %0d want 0", i, o_stall);
      else passes++;
      checks++;
      if (reqs !== 0) $display("FAIL err%0d_no_bus: got %0d req/stall cycles want 0", i, reqs);
      else passes++;
    end
  endtask

  task automatic test_reset_in_req();
    memenM = 1'b1; memwriteM = 1'b0; addrM = 32'h40; sizeM = 2'b10; unsignedM = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; memenM = 1'b0;
    @(negedge clk);
    checks++;
    if (bus_req !== 1'b1) $display("FAIL rstreq_in_req: got bus_req=%b want 1", bus_req);
    else passes++;
    @(posedge clk); #1;
    rst = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    checks++;
    if ({bus_req, stallM, rdataM} !== 34'h0)
      $display("FAIL rstreq_abandon: got req=%b stall=%b rdata=%h want 0 0 00000000", bus_req, stallM, rdataM);
    else passes++;
    @(posedge clk); #1;
    bus_ack = 1'b0; bus_rdata = 32'h0;
    @(negedge clk);
    checks++;
    if ({bus_req, stallM, rdataM} !== 34'h0)
      $display("FAIL rstreq_ack_ignored: got req=%b stall=%b rdata=%h want 0 0 00000000", bus_req, stallM, rdataM);
    else passes++;
    @(posedge clk); #1;
    exp_q.push_back('{1'b1, 32'h80, 4'b1111, 32'hCAFEF00D, 2, 32'h0});
    run_access(1'b1, 32'h80, 32'hCAFEF00D, 2'b10, 1'b0, 0, 32'h0, 1'b0);
    e = exp_q.pop_front();
    checks++;
    if ({o_sawreq, o_wr, o_addr, o_strb, o_wdata} !== {1'b1, e.wr, e.addr, e.strb, e.wdata} || o_stall !== e.stall)
      $display("FAIL rstreq_store: got req=%b wr=%b addr=%h strb=%b wdata=%h stall=%0d want 1 %b %h %b %h %0d",
               o_sawreq, o_wr, o_addr, o_strb, o_wdata, o_stall, e.wr, e.addr, e.strb, e.wdata, e.stall);
    else passes++;
    checks++;
    if (o_rdata !== e.rdata) $display("FAIL rstreq_store_rdata: got %h want %h", o_rdata, e.rdata);
    else passes++;
    last_rdata = e.rdata;
  endtask

  task automatic test_back_to_back();
    int first_done;
    exp_q.push_back('{1'b0, 32'h10, 4'h0, 32'h0, 2, 32'h11112222});
    exp_q.push_back('{1'b0, 32'h14, 4'h0, 32'h0, 2, 32'h33334444});
    run_access(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 0, 32'h11112222, 1'b1);
    first_done = o_done_cyc;
    e = exp_q.pop_front();
    checks++;
    if (o_stall !== e.stall || o_rdata !== e.rdata || o_addr !== e.addr)
      $display("FAIL b2b_first: got stall=%0d rdata=%h addr=%h want %0d %h %h", o_stall, o_rdata, o_addr, e.stall, e.rdata, e.addr);
    else passes++;
    run_access(1'b0, 32'h14, 32'h0, 2'b10, 1'b0, 0, 32'h33334444, 1'b0);
    e = exp_q.pop_front();
    checks++;
    if (o_req_cyc - first_done !== 2)
      $display("FAIL b2b_gap: got %0d cycles from DONE to bus_req want 2", o_req_cyc - first_done);
    else passes++;
    checks++;
    if (o_stall !== e.stall || o_rdata !== e.rdata || o_addr !== e.addr)
      $display("FAIL b2b_second: got stall=%0d rdata=%h addr=%h want %0d %h %h", o_stall, o_rdata, o_addr, e.stall, e.rdata, e.addr);
    else passes++;
  endtask

  initial begin
    rst = 1'b1; memenM = 1'b0; memwriteM = 1'b0; addrM = 32'h0; wdataM = 32'h0;
    sizeM = 2'b00; unsignedM = 1'b0; bus_ack = 1'b0; bus_rdata = 32'h0;
    last_rdata = 32'h0;
    test_reset();
    test_word_load();
    test_loads();
    test_stores();
    test_misaligned();
    test_reset_in_req();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
